// File: rtl/rst_sync_pkg.sv
// Shared constants for the reset conditioner: legal release-chain depths and stretch counter width.
package rst_sync_pkg;
    localparam int RST_SYNC_MIN_STAGES = 2;
    localparam int RST_SYNC_MAX_STAGES = 8;
    localparam int RST_SYNC_CNT_W      = 8;
endpackage : rst_sync_pkg

// File: rtl/rst_sync_chain.sv
// Release chain: synchronous set to all-ones, shift toward the tap when enabled, zero enters bit 0.
module rst_sync_chain
    import rst_sync_pkg::*;
#(
    parameter int NUM_STAGES = 2
) (
    input  logic clk_i,
    input  logic set_i,
    input  logic shift_en_i,
    output logic tap_o,
    output logic tap_d_o
);

    logic [NUM_STAGES-1:0] chain_q;
    logic [NUM_STAGES-1:0] chain_d;

    always_comb begin
        chain_d = chain_q;
        if (set_i) begin
            chain_d = '1;
        end else if (shift_en_i) begin
            chain_d = {chain_q[NUM_STAGES-2:0], 1'b0};
        end
    end

    // No initializer: the chain is undefined until the first set edge.
    always_ff @(posedge clk_i) begin
        chain_q <= chain_d;
    end

    assign tap_o   = chain_q[NUM_STAGES-1];
    assign tap_d_o = chain_d[NUM_STAGES-1];

endmodule : rst_sync_chain

// File: rtl/rst_sync_core.sv
// Reset conditioner: one-edge assertion, NUM_STAGES-edge release, one-cycle release pulse.
// Optional minimum-assertion stretch counter enabled by defining RST_SYNC_STRETCH_EN.
module rst_sync_core
    import rst_sync_pkg::*;
#(
    parameter int NUM_STAGES        = 2,
    parameter int MIN_ASSERT_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    output logic RST_SYNC,
    output logic RST_RELEASED
);

    if (NUM_STAGES < RST_SYNC_MIN_STAGES || NUM_STAGES > RST_SYNC_MAX_STAGES) begin : g_bad_stages
        $error("rst_sync_core: NUM_STAGES out of range 2..8");
    end
    if (MIN_ASSERT_CYCLES < 1 || MIN_ASSERT_CYCLES > 255) begin : g_bad_min
        $error("rst_sync_core: MIN_ASSERT_CYCLES out of range 1..255");
    end

    logic chain_set;
    logic sync_q;
    logic sync_d;
    logic released_q;
    logic released_d;

`ifdef RST_SYNC_STRETCH_EN
    localparam logic [RST_SYNC_CNT_W-1:0] CNT_LOAD = RST_SYNC_CNT_W'(MIN_ASSERT_CYCLES - 1);

    logic [RST_SYNC_CNT_W-1:0] cnt_q;
    logic [RST_SYNC_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (RST) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - RST_SYNC_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        cnt_q <= cnt_d;
    end

    // A nonzero counter keeps the chain pinned at all-ones even with RST low.
    assign chain_set = RST | (cnt_q != '0);
`else
    assign chain_set = RST;
`endif

    rst_sync_chain #(
        .NUM_STAGES (NUM_STAGES)
    ) u_chain (
        .clk_i      (CLK),
        .set_i      (chain_set),
        .shift_en_i (1'b1),
        .tap_o      (sync_q),
        .tap_d_o    (sync_d)
    );

    assign released_d = sync_q & ~sync_d;

    always_ff @(posedge CLK) begin
        released_q <= released_d;
    end

    assign RST_SYNC     = sync_q;
    assign RST_RELEASED = released_q;

endmodule : rst_sync_core

// File: tb/tb_rst_sync_core.sv
// Bench for rst_sync_core: three depths driven by one RST, checked against a low-edge-count model.
module tb_rst_sync_core;

    localparam int MIN_A = 6;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic s2, s3, s4, r2, r3, r4;

    int checks = 0;
    int errors = 0;
    int lows   = 0;   // consecutive RST=0 edges since the last RST=1 edge

    rst_sync_core #(.NUM_STAGES(2), .MIN_ASSERT_CYCLES(MIN_A)) u2 (
        .CLK(CLK), .RST(RST), .RST_SYNC(s2), .RST_RELEASED(r2));
    rst_sync_core #(.NUM_STAGES(3), .MIN_ASSERT_CYCLES(MIN_A)) u3 (
        .CLK(CLK), .RST(RST), .RST_SYNC(s3), .RST_RELEASED(r3));
    rst_sync_core #(.NUM_STAGES(4), .MIN_ASSERT_CYCLES(MIN_A)) u4 (
        .CLK(CLK), .RST(RST), .RST_SYNC(s4), .RST_RELEASED(r4));

    always #5 CLK = ~CLK;

    // Number of low edges after the last RST=1 edge at which RST_SYNC drops.
    function automatic int release_len(input int n);
`ifdef RST_SYNC_STRETCH_EN
        if (MIN_A + n - 1 > n) return MIN_A + n - 1;
`endif
        return n;
    endfunction

    function automatic logic exp_sync(input int n);
        return (lows < release_len(n)) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic exp_rel(input int n);
        return (lows == release_len(n)) ? 1'b1 : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %b expected %b (lows=%0d t=%0t)", tag, obs, exp, lows, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic step(input logic r);
        RST = r;
        @(posedge CLK);
        if (r) lows = 0;
        else if (lows < 100000) lows++;
        #1;
        chk("sync_n2", s2, exp_sync(2));
        chk("rel_n2",  r2, exp_rel(2));
        chk("sync_n3", s3, exp_sync(3));
        chk("rel_n3",  r3, exp_rel(3));
        chk("sync_n4", s4, exp_sync(4));
        chk("rel_n4",  r4, exp_rel(4));
    endtask

    initial begin
        // Reset held for three edges.
        repeat (3) step(1'b1);
        // Release and settle.
        repeat (8) step(1'b0);
        // Re-assertion in the middle of a release.
        step(1'b1);
        step(1'b0);
        step(1'b1);
        repeat (10) step(1'b0);
        // Single-edge pulse from idle.
        step(1'b1);
        repeat (12) step(1'b0);
        // Long idle.
        repeat (100) step(1'b0);
        // Random pulses and bursts.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        end
        repeat (12) step(1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rst_sync_core
